// File: rtl/divide_arbiter_pkg.sv
// Shared definitions for the divide arbiter slice.
// Contents:
//   OP_DIV / OP_MOD  request opcode encodings (quotient / remainder)
//   state_t          arbiter FSM state encoding
package divide_arbiter_pkg;

    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MOD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/divide_arbiter_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// A one-cycle pulse on en loads the operands; quotient/remainder are valid
// BITS cycles later, when done rises. done stays high while idle.
// The divider has no reset: a division in flight always runs to completion,
// and any power-up count value drains to zero on its own.
// Ports:
//   clk        clock
//   en         start pulse (operands sampled on the same edge)
//   dividend   BITS-wide dividend
//   divisor    BITS-wide divisor (never zero when started)
//   quotient   BITS-wide quotient
//   remainder  BITS-wide remainder
//   done       high when no division is in progress
module divide_arbiter_divider #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            en,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            done
);

    localparam int CW = $clog2(BITS + 1);

    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic [BITS-1:0] quo_r;
    logic [BITS-1:0] quo_s;
    logic [BITS-1:0] rem_r;
    logic [BITS-1:0] rem_s;
    logic [BITS-1:0] dvs_r;
    logic [BITS-1:0] dvs_s;
    logic [BITS:0]   trial_s;

    // Next-state of one restoring step: shift in the next dividend bit and
    // subtract the divisor if the partial remainder allows it.
    always_comb begin
        count_s = count_r;
        quo_s   = quo_r;
        rem_s   = rem_r;
        dvs_s   = dvs_r;
        // Borrow out of bit BITS means the partial remainder was smaller
        // than the divisor.
        trial_s = {rem_r, quo_r[BITS-1]} - {1'b0, dvs_r};
        if (en) begin
            count_s = CW'(BITS);
            quo_s   = dividend;
            rem_s   = {BITS{1'b0}};
            dvs_s   = divisor;
        end else if (count_r != {CW{1'b0}}) begin
            count_s = count_r - CW'(1);
            if (!trial_s[BITS]) begin
                rem_s = trial_s[BITS-1:0];
                quo_s = {quo_r[BITS-2:0], 1'b1};
            end else begin
                rem_s = {rem_r[BITS-2:0], quo_r[BITS-1]};
                quo_s = {quo_r[BITS-2:0], 1'b0};
            end
        end else begin
            count_s = count_r;
        end
    end

    // Iteration registers (intentionally without reset).
    always_ff @(posedge clk) begin
        count_r <= count_s;
        quo_r   <= quo_s;
        rem_r   <= rem_s;
        dvs_r   <= dvs_s;
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign done      = (count_r == {CW{1'b0}});

endmodule

// File: rtl/divide_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
// Each port raises req with op/a/b and holds them until its one-cycle ack;
// result carries the quotient (op=0) or remainder (op=1) during the ack.
// Divide-by-zero (q=all ones, r=a) and a repeat of the last divided
// operands (single-entry cache) answer one cycle after grant without
// touching the divider.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req0/op0/a0/b0      port 0 request, opcode, dividend, divisor
//   req1/op1/a1/b1      port 1 request, opcode, dividend, divisor
//   ack0, ack1          one-cycle completion pulses
//   result              shared result bus, valid while an ack is high
//   busy                high whenever the arbiter is not idle
module divide_arbiter
    import divide_arbiter_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            op0,
    input  logic [BITS-1:0] a0,
    input  logic [BITS-1:0] b0,
    input  logic            req1,
    input  logic            op1,
    input  logic [BITS-1:0] a1,
    input  logic [BITS-1:0] b1,
    output logic            ack0,
    output logic            ack1,
    output logic [BITS-1:0] result,
    output logic            busy
);

    state_t          state_r, state_s;
    logic            port_r, port_s;
    logic            op_r, op_s;
    logic [BITS-1:0] a_r, a_s;
    logic [BITS-1:0] b_r, b_s;
    logic [BITS-1:0] q_r, q_s;
    logic [BITS-1:0] r_r, r_s;
    logic            last_grant_r, last_grant_s;
    logic            cache_valid_r, cache_valid_s;
    logic [BITS-1:0] cache_a_r, cache_a_s;
    logic [BITS-1:0] cache_b_r, cache_b_s;
    logic [BITS-1:0] cache_q_r, cache_q_s;
    logic [BITS-1:0] cache_r_r, cache_r_s;
    logic            ack0_r, ack0_s;
    logic            ack1_r, ack1_s;
    logic [BITS-1:0] result_r, result_s;
    logic            busy_r, busy_s;

    logic            grant1_s;
    logic            sel_op_s;
    logic [BITS-1:0] sel_a_s;
    logic [BITS-1:0] sel_b_s;
    logic            div_en_s;
    logic            div_done_s;
    logic [BITS-1:0] div_q_s;
    logic [BITS-1:0] div_r_s;

    divide_arbiter_divider #(
        .BITS(BITS)
    ) u_divider (
        .clk       (clk),
        .en        (div_en_s),
        .dividend  (a_r),
        .divisor   (b_r),
        .quotient  (div_q_s),
        .remainder (div_r_s),
        .done      (div_done_s)
    );

    // Next-state, arbitration, fast paths, cache update and output values.
    always_comb begin
        state_s       = state_r;
        port_s        = port_r;
        op_s          = op_r;
        a_s           = a_r;
        b_s           = b_r;
        q_s           = q_r;
        r_s           = r_r;
        last_grant_s  = last_grant_r;
        cache_valid_s = cache_valid_r;
        cache_a_s     = cache_a_r;
        cache_b_s     = cache_b_r;
        cache_q_s     = cache_q_r;
        cache_r_s     = cache_r_r;
        div_en_s      = 1'b0;

        // Port 1 wins when it is the only requester, or when both request
        // and port 0 was the last one served.
        grant1_s = req1 & (~req0 | ~last_grant_r);
        sel_op_s = grant1_s ? op1 : op0;
        sel_a_s  = grant1_s ? a1  : a0;
        sel_b_s  = grant1_s ? b1  : b0;

        case (state_r)
            ST_IDLE: begin
                // A divider still busy from before a reset blocks new grants.
                if (div_done_s && (req0 || req1)) begin
                    port_s       = grant1_s;
                    last_grant_s = grant1_s;
                    op_s         = sel_op_s;
                    a_s          = sel_a_s;
                    b_s          = sel_b_s;
                    if (sel_b_s == {BITS{1'b0}}) begin
                        q_s     = {BITS{1'b1}};
                        r_s     = sel_a_s;
                        state_s = ST_RESP;
                    end else if (cache_valid_r && (sel_a_s == cache_a_r) &&
                                 (sel_b_s == cache_b_r)) begin
                        q_s     = cache_q_r;
                        r_s     = cache_r_r;
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                div_en_s = 1'b1;
                state_s  = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done_s) begin
                    q_s           = div_q_s;
                    r_s           = div_r_s;
                    cache_valid_s = 1'b1;
                    cache_a_s     = a_r;
                    cache_b_s     = b_r;
                    cache_q_s     = div_q_s;
                    cache_r_s     = div_r_s;
                    state_s       = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are registered on the edge entering RESP so that the ack
        // and result appear together for exactly the RESP cycle.
        ack0_s = (state_s == ST_RESP) && (port_s == 1'b0);
        ack1_s = (state_s == ST_RESP) && (port_s == 1'b1);
        if (state_s == ST_RESP) begin
            result_s = (op_s == OP_MOD) ? r_s : q_s;
        end else begin
            result_s = result_r;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latches, cache, round-robin pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_r        <= 1'b0;
            op_r          <= 1'b0;
            a_r           <= {BITS{1'b0}};
            b_r           <= {BITS{1'b0}};
            q_r           <= {BITS{1'b0}};
            r_r           <= {BITS{1'b0}};
            last_grant_r  <= 1'b1;
            cache_valid_r <= 1'b0;
            cache_a_r     <= {BITS{1'b0}};
            cache_b_r     <= {BITS{1'b0}};
            cache_q_r     <= {BITS{1'b0}};
            cache_r_r     <= {BITS{1'b0}};
            ack0_r        <= 1'b0;
            ack1_r        <= 1'b0;
            result_r      <= {BITS{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            port_r        <= port_s;
            op_r          <= op_s;
            a_r           <= a_s;
            b_r           <= b_s;
            q_r           <= q_s;
            r_r           <= r_s;
            last_grant_r  <= last_grant_s;
            cache_valid_r <= cache_valid_s;
            cache_a_r     <= cache_a_s;
            cache_b_r     <= cache_b_s;
            cache_q_r     <= cache_q_s;
            cache_r_r     <= cache_r_s;
            ack0_r        <= ack0_s;
            ack1_r        <= ack1_s;
            result_r      <= result_s;
            busy_r        <= busy_s;
        end
    end

    assign ack0   = ack0_r;
    assign ack1   = ack1_r;
    assign result = result_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_divide_arbiter.sv
// Self-checking bench for divide_arbiter: a transaction-level model predicts
// ack/busy/result every cycle, and directed requests carry hand-computed
// results and latencies.
module tb_divide_arbiter;

    localparam int BITS = 16;

    logic        clk;
    logic        rst  = 1'b0;
    logic        req0 = 1'b0;
    logic        op0  = 1'b0;
    logic [15:0] a0   = 16'd0;
    logic [15:0] b0   = 16'd0;
    logic        req1 = 1'b0;
    logic        op1  = 1'b0;
    logic [15:0] a1   = 16'd0;
    logic [15:0] b1   = 16'd0;
    logic        ack0;
    logic        ack1;
    logic [15:0] result;
    logic        busy;

    divide_arbiter #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int en_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc         = 0;   // number of the current clock cycle
    bit          m_pend      = 1'b0;
    int          m_ack_cyc   = 0;
    bit          m_port      = 1'b0;
    logic [15:0] m_res       = 16'd0;
    int          m_div_ready = 0;   // first cycle the divider reports done
    bit          m_last      = 1'b1;
    bit          m_cv        = 1'b0;
    logic [15:0] m_ca, m_cb, m_cq, m_cr;
    bit          exp_ack0 = 1'b0;
    bit          exp_ack1 = 1'b0;
    bit          exp_busy = 1'b0;

    task automatic model_step();
        bit          was_idle;
        bit          g1;
        bit          mop;
        logic [15:0] ma, mb, q, r;
        int          k;
        k = cyc;
        if (rst) begin
            m_pend = 1'b0;
            m_last = 1'b1;
            m_cv   = 1'b0;
        end else begin
            was_idle = !m_pend;
            if (m_pend && k == m_ack_cyc) m_pend = 1'b0;
            if (was_idle && k >= m_div_ready && (req0 || req1)) begin
                g1     = req1 && (!req0 || !m_last);
                m_last = g1;
                m_port = g1;
                mop    = g1 ? op1 : op0;
                ma     = g1 ? a1 : a0;
                mb     = g1 ? b1 : b0;
                m_pend = 1'b1;
                if (mb == 16'd0) begin
                    q = 16'hFFFF; r = ma; m_ack_cyc = k + 1;
                end else if (m_cv && ma == m_ca && mb == m_cb) begin
                    q = m_cq; r = m_cr; m_ack_cyc = k + 1;
                end else begin
                    q = ma / mb; r = ma % mb;
                    m_ack_cyc   = k + BITS + 3;
                    m_div_ready = k + BITS + 2;
                    m_cv = 1'b1; m_ca = ma; m_cb = mb; m_cq = q; m_cr = r;
                end
                m_res = mop ? r : q;
            end
        end
        cyc      = k + 1;
        exp_busy = m_pend;
        exp_ack0 = m_pend && (m_ack_cyc == cyc) && !m_port;
        exp_ack1 = m_pend && (m_ack_cyc == cyc) && m_port;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: DUT outputs against the model each cycle.
    initial forever begin
        @(posedge clk);
        #1;
        check("ack0", ack0, exp_ack0);
        check("ack1", ack1, exp_ack1);
        check("busy", busy, exp_busy);
        if (exp_ack0 || exp_ack1) check("result", result, m_res);
        if (dut.div_en_s) begin
            en_count++;
            check("en_while_div_busy", dut.div_done_s, 1'b1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic request(input bit p, input bit op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input int exp_lat, input string name,
                           input bit late, input logic [15:0] a_new);
        int start;
        bit got;
        start = cyc;
        got   = 1'b0;
        if (!p) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else    begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (late && i == 0) begin
                if (!p) a0 = a_new; else a1 = a_new;
            end
            if (p ? ack1 : ack0) begin
                got = 1'b1;
                check({name, "_result"}, result, exp_res);
                if (exp_lat >= 0) check({name, "_latency"}, cyc - start, exp_lat);
                if (!p) req0 = 1'b0; else req1 = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack within 200 cycles, ack required", name);
            if (!p) req0 = 1'b0; else req1 = 1'b0;
        end
    endtask

    int en_before;

    initial begin
        #1 rst = 1'b1;
        // Long enough for any power-up divider count to drain.
        repeat (40) @(negedge clk);
        check("reset_result", result, 16'd0);
        check("reset_ack0", ack0, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Port 0 DIV through the divider, then port 1 MOD hitting the cache.
        request(1'b0, 1'b0, 16'd100, 16'd7, 16'd14, 19, "div_100_7", 1'b0, 16'd0);
        @(negedge clk);
        en_before = en_count;
        request(1'b1, 1'b1, 16'd100, 16'd7, 16'd2, 1, "cache_mod", 1'b0, 16'd0);
        check("cache_no_en", en_count, en_before);

        // Divide by zero both ops; cache must survive.
        @(negedge clk);
        request(1'b0, 1'b0, 16'h1234, 16'd0, 16'hFFFF, 1, "dbz_div", 1'b0, 16'd0);
        @(negedge clk);
        request(1'b0, 1'b1, 16'h1234, 16'd0, 16'h1234, 1, "dbz_mod", 1'b0, 16'd0);
        @(negedge clk);
        en_before = en_count;
        request(1'b0, 1'b0, 16'd100, 16'd7, 16'd14, 1, "cache_kept", 1'b0, 16'd0);
        check("cache_kept_no_en", en_count, en_before);

        // Both ports requesting out of reset; port 0 re-raises immediately.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fork
            begin
                request(1'b0, 1'b0, 16'd50, 16'd5, 16'd10, 19, "rr_p0_first", 1'b0, 16'd0);
                request(1'b0, 1'b0, 16'd60, 16'd7, 16'd8, 40, "rr_p0_again", 1'b0, 16'd0);
            end
            begin
                request(1'b1, 1'b0, 16'd81, 16'd9, 16'd9, 39, "rr_p1", 1'b0, 16'd0);
            end
        join

        // Reset five cycles into a division; the divider must drain first.
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 16'd1000; b0 = 16'd3;
        repeat (5) @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        request(1'b0, 1'b0, 16'd65535, 16'd255, 16'd257, 31, "after_abort", 1'b0, 16'd0);

        // Operands changed after grant must not disturb the result.
        @(negedge clk);
        request(1'b0, 1'b0, 16'd100, 16'd3, 16'd33, 19, "late_change", 1'b1, 16'd200);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, finish required");
        $fatal(1, "watchdog");
    end

endmodule
